// File: rtl/exc_controller.sv
// Exception sequencer for the single-cycle datapath: latches IRQ / invalid-opcode
// causes, runs the Exc/ExcAck handshake, tracks handler residency and issues ERet.
module exc_controller #(
  parameter int NSRC        = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            invalid_op,
  input  logic            eret_instr,
  input  logic            cfg_we,
  input  logic [NSRC-1:0] cfg_mask,
  input  logic            ExcAck,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic            ERet,
  output logic            in_handler,
  output logic [NSRC-1:0] pending,
  output logic            double_fault,
  output logic            ack_timeout
);

  localparam int WDW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER, RETN} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            sync_pend_q, sync_pend_d;
  logic            cause_sync_q, cause_sync_d;
  logic [2:0]      cause_idx_q, cause_idx_d;
  logic [3:0]      estatus_q, estatus_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            double_fault_q, double_fault_d;
  logic            ack_timeout_q, ack_timeout_d;

  logic [NSRC-1:0] clr;
  logic [2:0]      win_idx;
  logic [WDW-1:0]  wd_nxt;

  // Lowest-index pending source wins among the interrupts.
  always_comb begin
    win_idx = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_q[i]) win_idx = 3'(i);
    end
  end

  assign wd_nxt = (wd_q == WDW'(ACK_TIMEOUT)) ? wd_q : wd_q + WDW'(1);

  always_comb begin
    state_d        = state_q;
    sync_pend_d    = sync_pend_q;
    mask_d         = mask_q;
    cause_sync_d   = cause_sync_q;
    cause_idx_d    = cause_idx_q;
    estatus_d      = estatus_q;
    wd_d           = wd_q;
    double_fault_d = double_fault_q;
    ack_timeout_d  = ack_timeout_q;
    clr            = '0;

    case (state_q)
      IDLE: begin
        if (sync_pend_q) begin
          state_d      = REQ;
          cause_sync_d = 1'b1;
          estatus_d    = 4'b0010;
          wd_d         = '0;
        end else if (|pending_q) begin
          state_d      = REQ;
          cause_sync_d = 1'b0;
          cause_idx_d  = win_idx;
          estatus_d    = {1'b1, win_idx};
          wd_d         = '0;
        end
        if (invalid_op) sync_pend_d = 1'b1;
      end
      REQ: begin
        if (ExcAck) begin
          state_d = HANDLER;
          if (cause_sync_q) begin
            sync_pend_d = 1'b0;
          end else begin
            for (int i = 0; i < NSRC; i++) begin
              if (cause_idx_q == 3'(i)) clr[i] = 1'b1;
            end
          end
        end else begin
          wd_d = wd_nxt;
          if (wd_nxt == WDW'(ACK_TIMEOUT)) ack_timeout_d = 1'b1;
        end
      end
      HANDLER: begin
        if (invalid_op) double_fault_d = 1'b1;
        if (eret_instr) begin
          state_d   = RETN;
          estatus_d = 4'b0000;
        end
      end
      RETN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // New requests win over a same-cycle accept clear.
    pending_d = (pending_q & ~clr) | (irq & mask_q);
    if (cfg_we) mask_d = cfg_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      mask_q         <= '1;
      sync_pend_q    <= 1'b0;
      cause_sync_q   <= 1'b0;
      cause_idx_q    <= 3'd0;
      estatus_q      <= 4'b0000;
      wd_q           <= '0;
      double_fault_q <= 1'b0;
      ack_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      mask_q         <= mask_d;
      sync_pend_q    <= sync_pend_d;
      cause_sync_q   <= cause_sync_d;
      cause_idx_q    <= cause_idx_d;
      estatus_q      <= estatus_d;
      wd_q           <= wd_d;
      double_fault_q <= double_fault_d;
      ack_timeout_q  <= ack_timeout_d;
    end
  end

  assign Exc          = (state_q == REQ);
  assign in_handler   = (state_q == HANDLER);
  assign ERet         = (state_q == RETN);
  assign EStatus      = estatus_q;
  assign pending      = pending_q;
  assign double_fault = double_fault_q;
  assign ack_timeout  = ack_timeout_q;

endmodule

// File: doc/exc_controller.md
Name: exc_controller

Overview:
- Sequences the datapath's exception interface: latches asynchronous interrupt requests and synchronous invalid-opcode events, prioritises them and drives Exc/EStatus.
- Runs the ExcAck handshake with the datapath, tracks handler residency and issues the one-cycle ERet pulse that returns the datapath to NextPC.
- Sits between the control unit / IRQ sources and the single-cycle datapath; owns no PC state itself.

Parameters:
- NSRC, 4, number of external interrupt sources (1..8).
- ACK_TIMEOUT, 16, cycles allowed in REQ without ExcAck before ack_timeout is flagged (>=2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- irq  input  NSRC  interrupt request lines, level/pulse, sampled every cycle
- invalid_op  input  1  control unit flags current instruction as undefined opcode
- eret_instr  input  1  control unit decodes an ERET instruction
- cfg_we  input  1  write strobe for interrupt mask
- cfg_mask  input  NSRC  new mask value, bit i = 1 enables irq[i]
- ExcAck  input  1  datapath acknowledges exception entry (PC redirected to EVAddr)
- Exc  output  1  exception request to datapath
- EStatus  output  4  cause code to datapath
- ERet  output  1  return-from-exception strobe to datapath
- in_handler  output  1  high while the handler executes
- pending  output  NSRC  latched unserviced interrupts (visible for debug)
- double_fault  output  1  sticky: invalid_op seen while in handler
- ack_timeout  output  1  sticky: ExcAck not received within ACK_TIMEOUT cycles

Behaviour:
- Reset (synchronous): state=IDLE; Exc=0, EStatus=0, ERet=0, in_handler=0, pending=0, sync_pend=0, double_fault=0, ack_timeout=0, wd counter=0, mask=all ones.
- Pending latch:
  - pending[i] <= pending[i] | (irq[i] & mask[i]) every cycle.
  - Cleared only on accept of source i; set and clear in the same cycle resolves to set.
  - sync_pend <= 1 on invalid_op in IDLE; cleared on its accept.
- Mask update: on cfg_we, mask <= cfg_mask next edge. Masking never clears already-latched pending bits.
- FSM states:
  - IDLE: if sync_pend or any pending -> REQ, latching the winning cause. Priority: sync_pend over lowest-index pending bit.
  - REQ: Exc=1, EStatus held constant. If ExcAck sampled high -> HANDLER and the serviced pending bit is cleared at that edge. Otherwise wd counter increments; at ACK_TIMEOUT, ack_timeout<=1 and the FSM stays in REQ (Exc kept high).
  - HANDLER: in_handler=1, Exc=0; further requests only latch into pending. eret_instr -> RETN. invalid_op -> double_fault<=1, state unchanged.
  - RETN: ERet=1 for exactly one cycle, EStatus cleared to 0 -> IDLE.
- EStatus encoding:
  - 4'b0000 none
  - 4'b0010 invalid opcode
  - {1'b1, idx[2:0]} for irq[idx]
  - All other codes reserved and never driven.
- Latency:
  - irq sampled high at edge t sets pending at t; Exc rises after edge t+1.
  - ExcAck sampled at edge k drops Exc and sets in_handler after edge k.
  - eret_instr at edge m raises ERet after m, which falls after m+1. Earliest re-entry to REQ is after m+2.
- All outputs are registered; no combinational path from inputs to outputs.
- ExcAck outside REQ and eret_instr outside HANDLER are ignored.
- Simultaneous invalid_op and irq in IDLE: invalid opcode is serviced first, and irq stays pending.
- Reset asserted in any state, including mid-handshake: all state cleared at that edge and Exc low the following cycle.
- wd counter is clog2(ACK_TIMEOUT+1) bits, saturating, and cleared on entry to REQ.

Test Plan:
- Reset, then irq=4'b0100 pulse one cycle -> pending=4'b0100 next cycle; Exc=1, EStatus=4'b1010 one cycle later; ExcAck -> Exc=0, in_handler=1, pending=0.
- invalid_op and irq[0] in the same IDLE cycle -> EStatus=4'b0010 first. After ack and eret: ERet high exactly one cycle, then second request with EStatus=4'b1000.
- Handshake in HANDLER, eret_instr pulse -> ERet=1 for one cycle, in_handler=0, EStatus=0, state IDLE.
- Hold ExcAck low for 16 cycles in REQ -> ack_timeout=1 and Exc still 1. Late ExcAck -> HANDLER normally; ack_timeout stays 1 until reset.
- cfg_mask=4'b1110, irq[0]=1 -> pending stays 0 and Exc never rises. With irq=4'b0011 -> EStatus=4'b1001.
- invalid_op while in HANDLER -> double_fault=1 with state unchanged. Reset asserted while in REQ -> Exc=0, double_fault=0 and pending=0 next cycle.
